// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment constants and the table decode,
// used by both the encoder and the scan decoder so their tables stay identical.
package seg7_pkg;

  // Segment order {g,f,e,d,c,b,a}; a 0 bit lights the segment.
  localparam logic [6:0] SEG7_0     = 7'b1000000;
  localparam logic [6:0] SEG7_1     = 7'b1111001;
  localparam logic [6:0] SEG7_2     = 7'b0100100;
  localparam logic [6:0] SEG7_3     = 7'b0110000;
  localparam logic [6:0] SEG7_4     = 7'b0011001;
  localparam logic [6:0] SEG7_5     = 7'b0010010;
  localparam logic [6:0] SEG7_6     = 7'b0000010;
  localparam logic [6:0] SEG7_7     = 7'b1111000;
  localparam logic [6:0] SEG7_8     = 7'b0000000;
  localparam logic [6:0] SEG7_9     = 7'b0010000;
  localparam logic [6:0] SEG7_A     = 7'b0001000;
  localparam logic [6:0] SEG7_B     = 7'b0000011;
  localparam logic [6:0] SEG7_C     = 7'b1000110;
  localparam logic [6:0] SEG7_D     = 7'b0100001;
  localparam logic [6:0] SEG7_E     = 7'b0000110;
  localparam logic [6:0] SEG7_F     = 7'b0001110;
  localparam logic [6:0] SEG7_BLANK = 7'b1111111;

  typedef struct packed {
    logic       hit;
    logic [3:0] nibble;
  } seg7_dec_t;

  // Pattern -> {hit, nibble}; hit is 0 for anything outside the 16-entry table.
  function automatic seg7_dec_t seg7_decode(input logic [6:0] seg);
    seg7_dec_t r;
    r.hit    = 1'b1;
    r.nibble = '0;
    case (seg)
      SEG7_0:  r.nibble = 4'h0;
      SEG7_1:  r.nibble = 4'h1;
      SEG7_2:  r.nibble = 4'h2;
      SEG7_3:  r.nibble = 4'h3;
      SEG7_4:  r.nibble = 4'h4;
      SEG7_5:  r.nibble = 4'h5;
      SEG7_6:  r.nibble = 4'h6;
      SEG7_7:  r.nibble = 4'h7;
      SEG7_8:  r.nibble = 4'h8;
      SEG7_9:  r.nibble = 4'h9;
      SEG7_A:  r.nibble = 4'hA;
      SEG7_B:  r.nibble = 4'hB;
      SEG7_C:  r.nibble = 4'hC;
      SEG7_D:  r.nibble = 4'hD;
      SEG7_E:  r.nibble = 4'hE;
      SEG7_F:  r.nibble = 4'hF;
      default: r.hit    = 1'b0;
    endcase
    return r;
  endfunction

  // Nibble -> pattern, the forward direction used by the display encoder.
  function automatic logic [6:0] seg7_encode(input logic [3:0] nibble);
    logic [6:0] s;
    s = SEG7_BLANK;
    case (nibble)
      4'h0: s = SEG7_0;
      4'h1: s = SEG7_1;
      4'h2: s = SEG7_2;
      4'h3: s = SEG7_3;
      4'h4: s = SEG7_4;
      4'h5: s = SEG7_5;
      4'h6: s = SEG7_6;
      4'h7: s = SEG7_7;
      4'h8: s = SEG7_8;
      4'h9: s = SEG7_9;
      4'hA: s = SEG7_A;
      4'hB: s = SEG7_B;
      4'hC: s = SEG7_C;
      4'hD: s = SEG7_D;
      4'hE: s = SEG7_E;
      default: s = SEG7_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_stable_detect.sv
// Stability detector: registers the input bus and strobes capture exactly once
// per dwell, after STABLE_CYCLES consecutive samples have matched.
module seg7_stable_detect #(
  parameter int unsigned WIDTH         = 9,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] held,
  output logic             capture
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_FIRE = CW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] s_reg;
  logic [CW-1:0]    cnt;
  logic             same;

  assign held = s_reg;

  // Capture strobe: input still matches the sample and the run just reached length.
  always_comb begin
    same    = (din == s_reg);
    capture = same && (cnt == CNT_FIRE);
  end

  // Sample register and saturating run-length counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_reg <= '1;
      cnt   <= '0;
    end else begin
      s_reg <= din;
      if (!same)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Scan decoder: reconstructs hex digits from a multiplexed active-low
// 7-segment bus, flags unknown patterns and pulses once per full refresh.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 2,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              ss_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   digit_seen,
  output logic                    frame_valid,
  output logic                    bad_pattern,
  output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] bad_index
);

  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [NUM_DIGITS+6:0] held;
  logic                  capture;
  logic [NUM_DIGITS-1:0] cap_sel;
  logic [6:0]            cap_seg;
  logic                  sel_onehot;
  logic [IW-1:0]         idx;
  seg7_dec_t             dec;
  logic [NUM_DIGITS-1:0] cap_mask;
  logic                  bad_hit;
  logic [NUM_DIGITS-1:0] seen_next;
  logic                  frame_done;

  seg7_stable_detect #(
    .WIDTH         (NUM_DIGITS + 7),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_stable (
    .clk     (clk),
    .reset   (reset),
    .din     ({dig_sel, ss_in}),
    .held    (held),
    .capture (capture)
  );

  // At capture the input equals the sample register, so decode from the register.
  always_comb begin
    cap_sel    = held[NUM_DIGITS+6:7];
    cap_seg    = held[6:0];
    sel_onehot = (cap_sel != '0) && ((cap_sel & (cap_sel - NUM_DIGITS'(1))) == '0);
    idx        = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++)
      if (cap_sel[i]) idx = IW'(i);
    dec        = seg7_decode(cap_seg);
    cap_mask   = (capture && sel_onehot && dec.hit) ? cap_sel : '0;
    bad_hit    = capture && sel_onehot && !dec.hit && (cap_seg != SEG7_BLANK);
    seen_next  = digit_seen | cap_mask;
    frame_done = &seen_next;
  end

  // Output registers: nibble store, seen tracking, frame and error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      digits_out  <= '0;
      digit_seen  <= '0;
      frame_valid <= 1'b0;
      bad_pattern <= 1'b0;
      bad_index   <= '0;
    end else begin
      frame_valid <= frame_done;
      bad_pattern <= bad_hit;
      if (bad_hit)
        bad_index <= idx;
      digit_seen  <= frame_done ? '0 : seen_next;
      for (int unsigned i = 0; i < NUM_DIGITS; i++)
        if (cap_mask[i])
          digits_out[4*i +: 4] <= dec.nibble;
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder (NUM_DIGITS=2, STABLE_CYCLES=4).
module tb_seg7_scan_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] ss_in;
  logic [1:0] dig_sel;
  logic [7:0] digits_out;
  logic [1:0] digit_seen;
  logic       frame_valid;
  logic       bad_pattern;
  logic [0:0] bad_index;

  int tests_run    = 0;
  int tests_failed = 0;
  int frame_cnt    = 0;
  int bad_cnt      = 0;
  int fc0, bc0;

  seg7_scan_decoder #(
    .NUM_DIGITS    (2),
    .STABLE_CYCLES (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ss_in       (ss_in),
    .dig_sel     (dig_sel),
    .digits_out  (digits_out),
    .digit_seen  (digit_seen),
    .frame_valid (frame_valid),
    .bad_pattern (bad_pattern),
    .bad_index   (bad_index)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (frame_valid) frame_cnt++;
    if (bad_pattern) bad_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dwell(input logic [1:0] sel, input logic [6:0] seg, input int n);
    dig_sel = sel;
    ss_in   = seg;
    repeat (n) tick();
  endtask

  initial begin
    reset   = 1'b1;
    dig_sel = 2'b00;
    ss_in   = 7'b1111111;
    repeat (3) tick();
    check_eq("rst_digits", digits_out, 32'h00);
    check_eq("rst_seen", digit_seen, 32'h0);
    check_eq("rst_frame", frame_valid, 32'h0);
    check_eq("rst_bad", bad_pattern, 32'h0);
    check_eq("rst_bidx", bad_index, 32'h0);
    reset = 1'b0;

    // Idle: blank with no digit selected.
    fc0 = frame_cnt; bc0 = bad_cnt;
    repeat (100) tick();
    check_eq("idle_frames", frame_cnt - fc0, 32'd0);
    check_eq("idle_bads", bad_cnt - bc0, 32'd0);
    check_eq("idle_digits", digits_out, 32'h00);
    check_eq("idle_seen", digit_seen, 32'h0);

    // 4-cycle dwell is too short; a 5-cycle dwell captures.
    dwell(2'b01, 7'b0010010, 4);
    dwell(2'b00, 7'b1111111, 1);
    check_eq("short_digits", digits_out, 32'h00);
    check_eq("short_seen", digit_seen, 32'h0);
    dwell(2'b01, 7'b0010010, 4);
    check_eq("d5_t4_digits", digits_out, 32'h00);
    tick();
    check_eq("d5_t5_digits", digits_out, 32'h05);
    check_eq("d5_t5_seen", digit_seen, 32'h1);
    repeat (20) tick();
    check_eq("d5_hold_frames", frame_cnt - fc0, 32'd0);
    check_eq("d5_hold_seen", digit_seen, 32'h1);

    // Full scans: 2 on digit 0, 3 on digit 1, 8-cycle dwells.
    reset = 1'b1; tick(); reset = 1'b0;
    fc0 = frame_cnt;
    dwell(2'b01, 7'b0100100, 8);
    check_eq("scan_a_digits", digits_out, 32'h02);
    check_eq("scan_a_seen", digit_seen, 32'h1);
    dwell(2'b10, 7'b0110000, 4);
    check_eq("scan_b4_frame", frame_valid, 32'h0);
    check_eq("scan_b4_seen", digit_seen, 32'h1);
    tick();
    check_eq("scan_b5_frame", frame_valid, 32'h1);
    check_eq("scan_b5_digits", digits_out, 32'h32);
    check_eq("scan_b5_seen", digit_seen, 32'h0);
    tick();
    check_eq("scan_b6_frame", frame_valid, 32'h0);
    tick(); tick();
    for (int s = 0; s < 2; s++) begin
      dwell(2'b01, 7'b0100100, 8);
      dwell(2'b10, 7'b0110000, 8);
    end
    check_eq("scan_frames", frame_cnt - fc0, 32'd3);

    // Recapture into an already-seen digit overwrites without a frame.
    fc0 = frame_cnt;
    dwell(2'b01, 7'b0010010, 8);
    check_eq("ovw1_digits", digits_out, 32'h35);
    dwell(2'b01, 7'b1000000, 8);
    check_eq("ovw2_digits", digits_out, 32'h30);
    check_eq("ovw_seen", digit_seen, 32'h1);
    check_eq("ovw_frames", frame_cnt - fc0, 32'd0);

    // Unknown pattern on digit 1, then on digit 0.
    bc0 = bad_cnt;
    dwell(2'b10, 7'b0101010, 5);
    check_eq("bad1_pulse", bad_pattern, 32'h1);
    check_eq("bad1_idx", bad_index, 32'h1);
    tick();
    check_eq("bad1_pulse_end", bad_pattern, 32'h0);
    repeat (4) tick();
    check_eq("bad1_count", bad_cnt - bc0, 32'd1);
    check_eq("bad1_digits", digits_out, 32'h30);
    check_eq("bad1_seen", digit_seen, 32'h1);
    dwell(2'b01, 7'b0101011, 10);
    check_eq("bad0_idx", bad_index, 32'h0);
    check_eq("bad0_count", bad_cnt - bc0, 32'd2);
    check_eq("bad0_digits", digits_out, 32'h30);

    // Non-one-hot selects are ignored.
    fc0 = frame_cnt; bc0 = bad_cnt;
    dwell(2'b11, 7'b1000000, 10);
    dwell(2'b00, 7'b1000000, 10);
    check_eq("nsel_digits", digits_out, 32'h30);
    check_eq("nsel_seen", digit_seen, 32'h1);
    check_eq("nsel_bads", bad_cnt - bc0, 32'd0);
    check_eq("nsel_frames", frame_cnt - fc0, 32'd0);

    // Bouncing segments never settle; the following F hold captures once.
    for (int b = 0; b < 4; b++)
      dwell(2'b01, (b % 2 == 0) ? 7'b0000000 : 7'b1111001, 3);
    check_eq("bounce_digits", digits_out, 32'h30);
    dwell(2'b01, 7'b0001110, 4);
    check_eq("f_t4_digits", digits_out, 32'h30);
    tick();
    check_eq("f_t5_digits", digits_out, 32'h3F);
    check_eq("f_frames", frame_cnt - fc0, 32'd0);

    // Reset at cnt=2 mid-dwell drops the pending capture.
    dwell(2'b10, 7'b1111001, 3);
    reset = 1'b1; tick();
    check_eq("mrst_digits", digits_out, 32'h00);
    check_eq("mrst_seen", digit_seen, 32'h0);
    check_eq("mrst_bidx", bad_index, 32'h0);
    reset = 1'b0;
    tick(); tick();
    check_eq("mrst_nocap", digits_out, 32'h00);
    check_eq("mrst_nocap_seen", digit_seen, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
